tube_scan_decoder: RTL and testbench
====================================

# tube_scan_decoder

Receive-side counterpart of the BCD-to-tube encoder path: observes a multiplexed 7-segment display bus (one-hot digit select plus shared GFEDCBA segment lines) and reconstructs the BCD value shown on every digit. It synchronizes the pin-level inputs, requires each (select, segment) pattern to be stable before committing it, and decodes segments back to BCD. It also reports per-digit invalid patterns, complete frames, and select-bus errors. It sits at the board input for display loopback checking and for reading an external tube-driven display.

## Interface
- DIGITS, 8, number of multiplexed digits (1..16)
- STABLE_CYCLES, 4, consecutive synchronized cycles a pattern must hold before commit (≥1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- seg_in  in  7  segment lines, GFEDCBA, active-high, asynchronous to clk
- dig_sel  in  DIGITS  digit select, active-high, expected one-hot or zero, asynchronous to clk
- digits_out  out  4*DIGITS  committed BCD per digit; digit i at [4i+3:4i]
- invalid_out  out  DIGITS  bit i set when digit i's last committed pattern was not a decimal glyph
- frame_valid  out  1  one-cycle pulse: every digit committed at least once since the last pulse or reset
- sel_err  out  1  one-cycle pulse: stable dig_sel had more than one bit set

## Operation
- seg_in and dig_sel each pass through a 2-flop synchronizer. All logic below uses the second stage.
- Stability counter:
  - Reset to 1 when the synchronized {dig_sel, seg} differs from its previous-cycle value; otherwise increments, saturating at STABLE_CYCLES.
  - A "stable event" occurs only on the cycle the counter transitions to STABLE_CYCLES, so there is exactly one event per stable period.
  - For STABLE_CYCLES=1, each change produces an event on its first cycle.
- On a stable event:
  - dig_sel == 0: blanking interval. No commit, no error.
  - dig_sel one-hot (bit i): commit digit i. digits_out[i] = decoded BCD. invalid_out[i] = 1 for a non-glyph pattern, else 0. Set seen_mask[i].
  - dig_sel with popcount ≥2: pulse sel_err. No commit, seen_mask unchanged.
- Decode set, exact match:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - Any other pattern, including 0x00, → BCD 4'hF with invalid set.
- Frame completion:
  - When a commit makes seen_mask all-ones, frame_valid pulses on the same edge that updates digits_out, and seen_mask clears to 0.
  - A commit to an already-seen digit overwrites its value but does not advance the frame.
- Reset values:
  - digits_out all 4'hF, invalid_out all 1, frame_valid 0, sel_err 0.
  - seen_mask 0, counter 0, synchronizers 0.
- Reset asserted mid-scan discards all partial state. The first frame after release needs all DIGITS commits.

## Timing
- An input change that lands before edge t is visible at the synchronizer output after edge t+1.
- digits_out and invalid_out update at edge t+1+STABLE_CYCLES. Total latency is STABLE_CYCLES+2 edges, counting the change edge.
- frame_valid and sel_err are registered. Each is high for exactly one cycle, aligned with the commit or reject edge.
- A glitch shorter than STABLE_CYCLES synchronized cycles never commits. The counter restarts on the return to the prior pattern, which then re-commits the same value. This is harmless: the value is idempotent and seen_mask is unchanged if already set.
- A pattern held indefinitely commits once.

## Structure
- tube_pkg holds:
  - SEG_GLYPH[10] constants matching the encoder table.
  - SEG_BLANK = 7'b0.
  - BCD_INVALID = 4'hF.
  - typedef seg_t (logic [6:0], GFEDCBA).
- The encoder and this block share tube_pkg.
- Sub-module tube_to_bcd is combinational: seg_t in; 4-bit bcd and valid out.
- Counter width is $clog2(STABLE_CYCLES+1).
- Top-level target is ~150–250 lines.

## Test plan
- Reset then idle → digits_out all 4'hF, invalid_out 0xFF, no pulses. Assert rst mid-frame after 3 commits → all outputs return to reset values, and the next frame needs 8 commits.
- Scan digits 0..7 with glyphs 0x3F,0x06,…,0x07, each held 6 cycles with 2 blank cycles between → digits_out = {7,6,5,4,3,2,1,0}, invalid_out 0x00, frame_valid pulses once on the digit-7 commit edge, latency 6 edges from the change.
- Hold dig_sel=0x04, seg=0x6D for 3 cycles, then 0x7D for 10 cycles → digit 2 = 6, exactly one commit; the 0x6D value never appears.
- dig_sel=0x01, seg=0x77 ("A") held 6 cycles → digit 0 = 4'hF, invalid_out[0]=1. Re-scan with 0x3F → digit 0 = 0, invalid_out[0]=0.
- dig_sel=0x03 stable, seg=0x06 → sel_err pulses once; digits_out and seen_mask unchanged; no frame_valid.
- STABLE_CYCLES=1 build with a pattern changing every cycle → one commit per change, latency 3 edges.

Source files
------------

// File: rtl/tube_pkg.sv
// Shared definitions for the tube (multiplexed 7-segment) encoder and decoder paths.
// Segment vectors are GFEDCBA, active-high; bit 0 is segment A.
package tube_pkg;

    typedef logic [6:0] seg_t;

    // Glyphs for BCD 0..9; must stay identical to the encoder's table.
    localparam seg_t SEG_GLYPH [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam seg_t       SEG_BLANK   = 7'b0;
    localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/tube_scan_decoder_if.sv
// Bundle between a multiplexed display bus and its decoder.
//   seg_in, dig_sel           : pin-level display bus (asynchronous to the decoder clock)
//   digits_out, invalid_out   : reconstructed BCD per digit and per-digit invalid flags
//   frame_valid, sel_err      : single-cycle status pulses
// master drives the display side, slave is the decoder.
interface tube_scan_decoder_if #(
    parameter int unsigned DIGITS = 8
);
    tube_pkg::seg_t          seg_in;
    logic [DIGITS-1:0]       dig_sel;
    logic [4*DIGITS-1:0]     digits_out;
    logic [DIGITS-1:0]       invalid_out;
    logic                    frame_valid;
    logic                    sel_err;

    modport master (
        output seg_in, dig_sel,
        input  digits_out, invalid_out, frame_valid, sel_err
    );

    modport slave (
        input  seg_in, dig_sel,
        output digits_out, invalid_out, frame_valid, sel_err
    );
endinterface

// File: rtl/tube_to_bcd.sv
// Combinational inverse of the BCD-to-segment encoder.
//   seg_i   : GFEDCBA pattern
//   bcd_o   : decoded digit, BCD_INVALID when the pattern is not a decimal glyph
//   valid_o : high when seg_i exactly matches one of the ten glyphs
module tube_to_bcd
    import tube_pkg::*;
(
    input  seg_t       seg_i,
    output logic [3:0] bcd_o,
    output logic       valid_o
);

    always_comb begin
        bcd_o   = BCD_INVALID;
        valid_o = 1'b0;
        for (int unsigned g = 0; g < 10; g++) begin
            if (seg_i == SEG_GLYPH[g]) begin
                bcd_o   = 4'(g);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tube_scan_decoder.sv
// Observes a multiplexed 7-segment bus and reconstructs the BCD value of every digit.
// Inputs are double-flop synchronized; a (select, segment) pair must hold for
// STABLE_CYCLES synchronized cycles before it is committed.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of tube_scan_decoder_if (display bus in, decoded state out)
module tube_scan_decoder
    import tube_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    tube_scan_decoder_if.slave   bus
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t CntMax = cnt_t'(STABLE_CYCLES);

    seg_t              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
    logic [DIGITS-1:0] sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, sel_prev_q, sel_prev_d;
    cnt_t              cnt_q, cnt_d;

    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [DIGITS-1:0]   invalid_q, invalid_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic                frame_valid_q, frame_valid_d;
    logic                sel_err_q, sel_err_d;

    logic              changed;
    logic              stable_evt;
    logic              sel_none;
    logic              sel_onehot;
    logic [DIGITS-1:0] seen_next;
    logic [3:0]        dec_bcd;
    logic              dec_valid;

    tube_to_bcd u_dec (
        .seg_i   (seg_s2_q),
        .bcd_o   (dec_bcd),
        .valid_o (dec_valid)
    );

    always_comb begin
        seg_s1_d   = bus.seg_in;
        sel_s1_d   = bus.dig_sel;
        seg_s2_d   = seg_s1_q;
        sel_s2_d   = sel_s1_q;
        seg_prev_d = seg_s2_q;
        sel_prev_d = sel_s2_q;

        changed = {sel_s2_q, seg_s2_q} != {sel_prev_q, seg_prev_q};
        if (changed) begin
            cnt_d = cnt_t'(1);
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + cnt_t'(1);
        end
        // Fire only on the transition into CntMax. With STABLE_CYCLES=1 a change
        // reloads 1 == CntMax, so the change itself is the transition.
        stable_evt = (cnt_d == CntMax) && (changed || (cnt_q != CntMax));

        sel_none   = (sel_s2_q == '0);
        // Clearing the lowest set bit leaves zero only for a single-bit vector.
        sel_onehot = !sel_none && ((sel_s2_q & (sel_s2_q - DIGITS'(1))) == '0);

        digits_d      = digits_q;
        invalid_d     = invalid_q;
        seen_d        = seen_q;
        seen_next     = seen_q | sel_s2_q;
        frame_valid_d = 1'b0;
        sel_err_d     = 1'b0;

        if (stable_evt) begin
            if (sel_onehot) begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (sel_s2_q[i]) begin
                        digits_d[4*i +: 4] = dec_bcd;
                        invalid_d[i]       = !dec_valid;
                    end
                end
                if (seen_next == '1) begin
                    frame_valid_d = 1'b1;
                    seen_d        = '0;
                end else begin
                    seen_d = seen_next;
                end
            end else if (!sel_none) begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q      <= SEG_BLANK;
            seg_s2_q      <= SEG_BLANK;
            seg_prev_q    <= SEG_BLANK;
            sel_s1_q      <= '0;
            sel_s2_q      <= '0;
            sel_prev_q    <= '0;
            cnt_q         <= '0;
            digits_q      <= {DIGITS{BCD_INVALID}};
            invalid_q     <= '1;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            seg_s1_q      <= seg_s1_d;
            seg_s2_q      <= seg_s2_d;
            seg_prev_q    <= seg_prev_d;
            sel_s1_q      <= sel_s1_d;
            sel_s2_q      <= sel_s2_d;
            sel_prev_q    <= sel_prev_d;
            cnt_q         <= cnt_d;
            digits_q      <= digits_d;
            invalid_q     <= invalid_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            sel_err_q     <= sel_err_d;
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.invalid_out = invalid_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sel_err     = sel_err_q;

endmodule

// File: tb/tb_tube_scan_decoder.sv
// Scoreboard bench: stimulus pushes the expected visible event (edge number, digit
// state, pulses); per-DUT monitors pop and compare whenever outputs change or pulse.
// dut0 uses STABLE_CYCLES=4, dut1 uses STABLE_CYCLES=1.
module tb_tube_scan_decoder;

    localparam int unsigned DIGITS = 8;

    typedef struct {
        int          cyc;
        logic [31:0] dig;
        logic [7:0]  inv;
        logic        frame;
        logic        selerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [31:0] m0_dig = 32'hFFFF_FFFF;
    logic [7:0]  m0_inv = 8'hFF;
    logic [31:0] m1_dig = 32'hFFFF_FFFF;
    logic [7:0]  m1_inv = 8'hFF;

    // Hand-written glyph table for digits 0..9.
    logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tube_scan_decoder_if #(.DIGITS(DIGITS)) bus0 ();
    tube_scan_decoder_if #(.DIGITS(DIGITS)) bus1 ();

    tube_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    tube_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic check_evt(input string name, input exp_t a, input exp_t e);
        checks++;
        if (a.cyc != e.cyc || a.dig !== e.dig || a.inv !== e.inv ||
            a.frame !== e.frame || a.selerr !== e.selerr) begin
            failures++;
            $display("FAIL %s: got cyc=%0d dig=%h inv=%h frame=%b selerr=%b, want cyc=%0d dig=%h inv=%h frame=%b selerr=%b",
                     name, a.cyc, a.dig, a.inv, a.frame, a.selerr,
                     e.cyc, e.dig, e.inv, e.frame, e.selerr);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitors
    logic [31:0] p0_dig, p1_dig;
    logic [7:0]  p0_inv, p1_inv;
    exp_t        a0, e0, a1, e1;

    always @(negedge clk) begin
        if (rst) begin
            p0_dig = bus0.digits_out;
            p0_inv = bus0.invalid_out;
        end else begin
            if (bus0.digits_out !== p0_dig || bus0.invalid_out !== p0_inv ||
                bus0.frame_valid || bus0.sel_err) begin
                a0 = '{cyc, bus0.digits_out, bus0.invalid_out, bus0.frame_valid, bus0.sel_err};
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut0_unexpected: got cyc=%0d dig=%h inv=%h frame=%b selerr=%b, want no event",
                             a0.cyc, a0.dig, a0.inv, a0.frame, a0.selerr);
                end else begin
                    e0 = q0.pop_front();
                    check_evt("dut0_event", a0, e0);
                end
            end
            p0_dig = bus0.digits_out;
            p0_inv = bus0.invalid_out;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            p1_dig = bus1.digits_out;
            p1_inv = bus1.invalid_out;
        end else begin
            if (bus1.digits_out !== p1_dig || bus1.invalid_out !== p1_inv ||
                bus1.frame_valid || bus1.sel_err) begin
                a1 = '{cyc, bus1.digits_out, bus1.invalid_out, bus1.frame_valid, bus1.sel_err};
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut1_unexpected: got cyc=%0d dig=%h inv=%h frame=%b selerr=%b, want no event",
                             a1.cyc, a1.dig, a1.inv, a1.frame, a1.selerr);
                end else begin
                    e1 = q1.pop_front();
                    check_evt("dut1_event", a1, e1);
                end
            end
            p1_dig = bus1.digits_out;
            p1_inv = bus1.invalid_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [7:0] sel, input logic [6:0] seg);
        bus0.dig_sel = sel;
        bus0.seg_in  = seg;
    endtask

    // Drive one pattern on dut0; idx<0 means no commit expected. An event is queued
    // whenever the expected digit state changes or a pulse is expected.
    task automatic scan0(input logic [7:0] sel, input logic [6:0] seg, input int idx,
                         input logic [3:0] bcd, input logic inv, input logic frame,
                         input logic selerr, input int hold, input int blank);
        logic [31:0] old_dig;
        logic [7:0]  old_inv;
        int          k;
        drive0(sel, seg);
        k       = cyc;
        old_dig = m0_dig;
        old_inv = m0_inv;
        if (idx >= 0) begin
            m0_dig[4*idx +: 4] = bcd;
            m0_inv[idx]        = inv;
        end
        if (m0_dig != old_dig || m0_inv != old_inv || frame || selerr)
            q0.push_back('{k + 6, m0_dig, m0_inv, frame, selerr});
        tick(hold);
        drive0(8'h00, 7'h00);
        tick(blank);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        m0_dig = 32'hFFFF_FFFF;
        m0_inv = 8'hFF;
        m1_dig = 32'hFFFF_FFFF;
        m1_inv = 8'hFF;
        tick(5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int k;
        drive0(8'h00, 7'h00);
        bus1.dig_sel = 8'h00;
        bus1.seg_in  = 7'h00;
        #2;
        do_reset();

        // Reset then idle
        tick(10);
        check_val("reset_digits0", bus0.digits_out, 32'hFFFF_FFFF);
        check_val("reset_invalid0", {24'h0, bus0.invalid_out}, 32'hFF);
        check_val("reset_pulses0", {30'h0, bus0.frame_valid, bus0.sel_err}, 32'h0);
        check_val("reset_digits1", bus1.digits_out, 32'hFFFF_FFFF);

        // Full scan 0..7, frame on digit 7
        for (int j = 0; j < 8; j++)
            scan0(8'(1 << j), glyph[j], j, 4'(j), 1'b0, j == 7, 1'b0, 6, 2);
        check_val("scan_digits", bus0.digits_out, 32'h7654_3210);
        check_val("scan_invalid", {24'h0, bus0.invalid_out}, 32'h0);

        // Short 0x6D glitch never commits; 0x7D commits once
        drive0(8'h04, 7'h6D);
        tick(3);
        drive0(8'h04, 7'h7D);
        k = cyc;
        m0_dig[11:8] = 4'd6;
        q0.push_back('{k + 6, m0_dig, m0_inv, 1'b0, 1'b0});
        tick(10);
        drive0(8'h00, 7'h00);
        tick(2);

        // Non-glyph, then valid re-scan
        scan0(8'h01, 7'h77, 0, 4'hF, 1'b1, 1'b0, 1'b0, 6, 2);
        scan0(8'h01, 7'h3F, 0, 4'h0, 1'b0, 1'b0, 1'b0, 6, 2);

        // Multi-hot select: error pulse only
        scan0(8'h03, 7'h06, -1, 4'h0, 1'b0, 1'b0, 1'b1, 6, 2);

        // seen = {0,2}: frame must land on the digit-1 commit, not earlier
        scan0(8'h08, 7'h6F, 3, 4'd9, 1'b0, 1'b0, 1'b0, 6, 2);
        scan0(8'h10, 7'h7F, 4, 4'd8, 1'b0, 1'b0, 1'b0, 6, 2);
        scan0(8'h20, 7'h07, 5, 4'd7, 1'b0, 1'b0, 1'b0, 6, 2);
        scan0(8'h40, 7'h6D, 6, 4'd5, 1'b0, 1'b0, 1'b0, 6, 2);
        scan0(8'h80, 7'h66, 7, 4'd4, 1'b0, 1'b0, 1'b0, 6, 2);
        scan0(8'h02, 7'h4F, 1, 4'd3, 1'b0, 1'b1, 1'b0, 6, 2);
        check_val("refill_digits", bus0.digits_out, 32'h4578_9630);

        // Three commits then reset mid-frame
        scan0(8'h01, 7'h5B, 0, 4'd2, 1'b0, 1'b0, 1'b0, 6, 2);
        scan0(8'h02, 7'h06, 1, 4'd1, 1'b0, 1'b0, 1'b0, 6, 2);
        scan0(8'h04, 7'h3F, 2, 4'd0, 1'b0, 1'b0, 1'b0, 6, 2);
        do_reset();
        check_val("midreset_digits", bus0.digits_out, 32'hFFFF_FFFF);
        check_val("midreset_invalid", {24'h0, bus0.invalid_out}, 32'hFF);
        check_val("midreset_pulses", {30'h0, bus0.frame_valid, bus0.sel_err}, 32'h0);

        // Fresh frame needs all 8 commits; digit 5 gets a blank (0x00) pattern
        for (int j = 0; j < 8; j++) begin
            if (j == 5)
                scan0(8'h20, 7'h00, 5, 4'hF, 1'b1, 1'b0, 1'b0, 6, 2);
            else
                scan0(8'(1 << j), glyph[j], j, 4'(j), 1'b0, j == 7, 1'b0, 6, 2);
        end
        check_val("post_digits", bus0.digits_out, 32'h76F4_3210);
        check_val("post_invalid", {24'h0, bus0.invalid_out}, 32'h20);

        // STABLE_CYCLES=1: new pattern every cycle, each commits 3 edges after its change
        for (int j = 0; j < 8; j++) begin
            bus1.dig_sel = 8'(1 << j);
            bus1.seg_in  = glyph[j];
            k = cyc;
            m1_dig[4*j +: 4] = 4'(j);
            m1_inv[j]        = 1'b0;
            q1.push_back('{k + 3, m1_dig, m1_inv, j == 7, 1'b0});
            tick(1);
        end
        bus1.dig_sel = 8'h00;
        bus1.seg_in  = 7'h00;
        tick(20);
        check_val("fast_digits", bus1.digits_out, 32'h7654_3210);

        check_val("q0_drained", q0.size(), 32'd0);
        check_val("q1_drained", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
